muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle RV32M controller beside the Execute-stage ALU. Takes MUL/MULH/MULHSU/MULHU/
//  DIV/DIVU/REM/REMU, runs a shared iterative shift-add / restoring-divide datapath, and
//  stalls the pipeline until the result is ready. Decode raises start for opcode 0110011
//  with func7=0000001; the result is muxed onto regWriteData in the cycle done=1.
// PARAMETERS
//  XLEN   32   operand/result width; the iteration count equals XLEN
// PORTS
//  clk       in   1     clock
//  reset     in   1     synchronous, active-high reset
//  start     in   1     M-instruction present in EX; held until the pipeline advances
//  func3     in   3     0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  rs1_data  in   XLEN  operand A (multiplicand / dividend)
//  rs2_data  in   XLEN  operand B (multiplier / divisor)
//  flush     in   1     abort: the branch/jump in a later stage redirects PC
//  stall     out  1     hold IF/ID/EX registers
//  busy      out  1     state != IDLE
//  done      out  1     one-cycle pulse; result valid in this cycle
//  result    out  XLEN  registered result; holds its last value until the next done
// BEHAVIOUR
//  Reset: state=IDLE; stall=busy=done=0; result=0; counter and internal registers = 0.
//  States are IDLE, CALC, SIGN and DONE.
//  - IDLE: start=1 latches func3, operand magnitudes, sign flags and cnt=0.
//    - Divisor 0, or DIV/REM with A=0x80000000 and B=0xFFFFFFFF: go to DONE with the special result.
//    - Otherwise go to CALC.
//  - CALC: one step per cycle, cnt++; after the step with cnt=XLEN-1, go to SIGN.
//    - MUL step: if multiplier LSB, add multiplicand into the upper half of a 2*XLEN accumulator,
//      then shift right 1 (carry kept).
//    - DIV step: shift remainder:quotient left 1; if rem >= |B|, rem -= |B| and set the quotient LSB.
//  - SIGN: negate per the sign rules, select the output word, register it into result; go to DONE.
//  - DONE: done=1 and stall=0, so the pipeline advances this cycle. Unconditional return to IDLE;
//    start is ignored in DONE, because it is still the same instruction.
//  stall = (IDLE & start & ~flush) | CALC | SIGN. It is combinational, so it is high in the accept cycle.
//  Latency from the start edge: normal ops give done 33 cycles later (1+32); special cases give 1.
//  Signedness: MULH treats A and B as signed; MULHSU treats A signed, B unsigned; MULHU and DIVU/REMU
//    are unsigned. MUL is sign-agnostic and uses the low word of the unsigned product.
//  Sign fix: a product is negated when sign(A)^sign(B). A quotient is negated when sA^sB. A remainder
//    takes the sign of the dividend. Magnitudes are 2's complement, and |0x80000000| = 0x80000000.
//  Output word: MUL gives product[XLEN-1:0]. MULH* gives product[2*XLEN-1:XLEN]. DIV* gives the
//    quotient. REM* gives the remainder.
//  Divide by zero: quotient = all ones (DIV and DIVU); remainder = A.
//  Overflow: DIV 0x80000000/-1 = 0x80000000; REM = 0.
//  flush, in any state other than DONE, forces IDLE at the next edge. No done follows, result is
//    unchanged, and stall drops in that same cycle.
//  reset mid-operation behaves as reset, with no done.
//  Operands are sampled only on accept; later changes on rs1_data/rs2_data are ignored.
// TESTING
//  - MUL 7 x -3 (0x7, 0xFFFFFFFD): stall for 33 cycles, then done with result 0xFFFFFFEB.
//    Also check the stall count and the done width.
//  - MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF x 0x2 -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14 and REMU 100/7 -> 2.
//  - DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done one cycle after accept.
//    DIV 0x80000000/-1 -> 0x80000000, also with done one cycle after accept.
//  - flush at cycle 10 of CALC: IDLE next edge, no done, result keeps its prior value.
//    A new start on the following cycle is accepted normally.
//  - start held through DONE: exactly one done per instruction.
//    reset asserted mid-CALC: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer_if
//  Description : Execute-stage handshake between the pipeline and the RV32M
//                multi-cycle sequencer.
//                master : pipeline side, drives start/func3/operands/flush
//                slave  : sequencer side, drives stall/busy/done/result
//  Signals     : start, func3[2:0], rs1_data, rs2_data, flush      (to seq)
//                stall, busy, done, result                         (from seq)
//  Revision    : 1.0  initial release
// ============================================================================
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, func3, rs1_data, rs2_data, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, func3, rs1_data, rs2_data, flush,
    output stall, busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative RV32M unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//                sharing one 2*XLEN accumulator between a shift-add multiplier
//                and a restoring divider. Stalls the pipeline until done.
//  Ports       : clk    - clock
//                reset  - synchronous, active-high reset
//                mdu    - muldiv_sequencer_if.slave (start/func3/rs1_data/
//                         rs2_data/flush in; stall/busy/done/result out)
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   mdu
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ONES = {XLEN{1'b1}};

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d;
  logic [XLEN-1:0]   opb_q, opb_d;      // multiplicand |A| or divisor |B|
  logic [2*XLEN-1:0] acc_q, acc_d;      // {hi, lo}: product, or {rem, quot}
  logic              neg_q, neg_d;      // negate the selected output word
  logic [XLEN-1:0]   result_q, result_d;

  // --------------------------------------------------------------------------
  // Accept-time decode
  // --------------------------------------------------------------------------
  logic            w_is_div;
  logic            w_signed_a, w_signed_b;
  logic            w_sa, w_sb;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div_zero, w_div_ovf;
  logic [XLEN-1:0] w_special;

  always_comb begin
    w_is_div   = mdu.func3[2];
    // MULH, MULHSU, DIV, REM read A as signed; MULH, DIV, REM read B as signed
    w_signed_a = (mdu.func3 == 3'd1) || (mdu.func3 == 3'd2) ||
                 (mdu.func3 == 3'd4) || (mdu.func3 == 3'd6);
    w_signed_b = (mdu.func3 == 3'd1) || (mdu.func3 == 3'd4) ||
                 (mdu.func3 == 3'd6);
    w_sa       = w_signed_a & mdu.rs1_data[XLEN-1];
    w_sb       = w_signed_b & mdu.rs2_data[XLEN-1];
    // Negating the most negative value wraps to itself, which read unsigned
    // is exactly its magnitude.
    w_mag_a    = w_sa ? (~mdu.rs1_data + 1'b1) : mdu.rs1_data;
    w_mag_b    = w_sb ? (~mdu.rs2_data + 1'b1) : mdu.rs2_data;
    w_div_zero = w_is_div && (mdu.rs2_data == '0);
    w_div_ovf  = ((mdu.func3 == 3'd4) || (mdu.func3 == 3'd6)) &&
                 (mdu.rs1_data == C_MIN) && (mdu.rs2_data == C_ONES);
    // func3[1] distinguishes REM* from DIV* among the divide ops
    if (w_div_zero) begin
      w_special = mdu.func3[1] ? mdu.rs1_data : C_ONES;
    end else begin
      w_special = mdu.func3[1] ? '0 : C_MIN;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath step
  // --------------------------------------------------------------------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_sh;          // shifted remainder needs one extra bit
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_sub;
  logic [2*XLEN-1:0] w_div_next;

  always_comb begin
    if (acc_q[0]) begin
      w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    end else begin
      w_mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]};
    end
    // Carry from the add drops into the top bit on the right shift
    w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

    w_rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    w_ge       = (w_rem_sh >= {1'b0, opb_q});
    // When w_ge holds the difference is below |B|, so the low word suffices
    w_rem_sub  = w_rem_sh[XLEN-1:0] - opb_q;
    w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0]),
                  acc_q[XLEN-2:0], w_ge};
  end

  // --------------------------------------------------------------------------
  // Sign fix and output word selection
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot, w_rem;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    w_quot = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    w_rem  = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (func3_q)
      3'd0:          w_final = w_prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          w_final = w_prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:    w_final = w_quot;
      default:       w_final = w_rem;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func3_d  = func3_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (mdu.start && !mdu.flush) begin
          func3_d = mdu.func3;
          cnt_d   = '0;
          // Remainder follows the dividend only; everything else uses sA^sB
          neg_d   = (mdu.func3 == 3'd6) ? w_sa : (w_sa ^ w_sb);
          if (w_is_div) begin
            opb_d = w_mag_b;
            acc_d = {{XLEN{1'b0}}, w_mag_a};
          end else begin
            opb_d = w_mag_a;
            acc_d = {{XLEN{1'b0}}, w_mag_b};
          end
          if (w_div_zero || w_div_ovf) begin
            result_d = w_special;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = func3_q[2] ? w_div_next : w_mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_SIGN;
          end
        end
      end
      S_SIGN: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = w_final;
          state_d  = S_DONE;
        end
      end
      default: begin
        // The instruction retires here; a still-high start is the same one
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      func3_q  <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func3_q  <= func3_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  // A flush releases the pipeline immediately, even mid-calculation
  assign mdu.stall  = !mdu.flush &&
                      (((state_q == S_IDLE) && mdu.start) ||
                       (state_q == S_CALC) || (state_q == S_SIGN));
  assign mdu.busy   = (state_q != S_IDLE);
  assign mdu.done   = (state_q == S_DONE);
  assign mdu.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer. Vector table of
//                operations with expected results; expected values go into a
//                queue at accept and are popped when done is seen. Hand-made
//                sequences cover flush, reset mid-operation and latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;
  logic [31:0] last_exp = 32'h0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done, result 0x%08h",
                 bus.result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scoreboard_result", bus.result, mon_exp);
        last_exp = mon_exp;
      end
    end
  end

  // One instruction: start held through DONE, dropped when the pipe advances.
  // Normal ops stall 33 cycles after the accept cycle, done in the 34th;
  // special cases give done in the cycle right after accept.
  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic special);
    int  lat;
    int  stalls;
    bit  seen;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.start    = 1'b1;
    bus.func3    = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    exp_q.push_back(exp);
    @(negedge clk);
    check({name, "_accept_stall"}, {31'b0, bus.stall}, 32'd1);
    check({name, "_accept_busy"}, {31'b0, bus.busy}, 32'd0);
    check({name, "_held_result"}, bus.result, last_exp);
    @(posedge clk); #1;
    // Operands after accept must not matter
    bus.rs1_data = $urandom;
    bus.rs2_data = $urandom;
    lat = 0; stalls = 0; seen = 0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) seen = 1;
      else if (bus.stall) stalls++;
    end
    check({name, "_latency"}, lat, special ? 32'd1 : 32'd34);
    check({name, "_stall_cycles"}, stalls, special ? 32'd0 : 32'd33);
    check({name, "_stall_in_done"}, {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check({name, "_done_width"}, {31'b0, bus.done}, 32'd0);
    check({name, "_no_reaccept"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{3'd4, 32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0};
    vecs[13] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0};
    vecs[14] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[15] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[16] = '{3'd4, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b1};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.func3    = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stall",  {31'b0, bus.stall}, 32'd0);
    check("reset_busy",   {31'b0, bus.busy},  32'd0);
    check("reset_done",   {31'b0, bus.done},  32'd0);
    check("reset_result", bus.result,         32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].special);
    end

    // Flush after 10 CALC cycles: no done, result kept, restart next cycle
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.func3    = 3'd0;
    bus.rs1_data = 32'd3;
    bus.rs2_data = 32'd5;
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("flush_stall_drops", {31'b0, bus.stall}, 32'd0);
    check("flush_busy_calc",   {31'b0, bus.busy},  32'd1);
    // run_op clears flush at the next edge and starts immediately; its accept
    // checks confirm IDLE and that the result kept its prior value
    run_op("after_flush", 3'd5, 32'd1000, 32'd10, 32'd100, 1'b0);

    // Reset mid-CALC
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.func3    = 3'd7;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    repeat (6) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_stall",  {31'b0, bus.stall}, 32'd0);
    check("midreset_busy",   {31'b0, bus.busy},  32'd0);
    check("midreset_done",   {31'b0, bus.done},  32'd0);
    check("midreset_result", bus.result,         32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    last_exp = 32'd0;

    run_op("after_reset", 3'd3, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 1'b0);

    repeat (40) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
